// File: rtl/wb_dual_write_seq.sv
// Writeback sequencer: turns registered ALU results into register-file writes on one port.
// Multiply/divide produce two writes (rd then HI_REG) and stall upstream for one cycle.
module wb_dual_write_seq #(
  parameter int unsigned     DATA_W    = 16,
  parameter int unsigned     ADDR_W    = 4,
  parameter logic [ADDR_W-1:0] HI_REG  = 4'd15,
  parameter logic [3:0]      MULT_CODE = 4'b0010,
  parameter logic [3:0]      DIV_CODE  = 4'b0011
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_op1,
  input  logic [DATA_W-1:0] in_r15,
  input  logic [3:0]        in_control,
  input  logic [ADDR_W-1:0] in_rd,
  input  logic              in_wr_en,
  input  logic              flush,
  output logic              rf_we,
  output logic [ADDR_W-1:0] rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  output logic [15:0]       retired
);

  // state | meaning
  // IDLE  | no write on the outputs
  // WR1   | first (or only) write of an instruction on the outputs
  // WR2   | HI_REG write of a dual op on the outputs
  typedef enum logic [1:0] {IDLE, WR1, WR2} state_t;

  state_t              r_state;
  logic                r_pend_dual;
  logic [DATA_W-1:0]   r_r15;
  logic                r_rf_we;
  logic [ADDR_W-1:0]   r_rf_waddr;
  logic [DATA_W-1:0]   r_rf_wdata;
  logic [15:0]         r_retired;

  logic w_dual;
  logic w_accept;
  logic w_last_write;

  assign w_dual   = (in_control == MULT_CODE) || (in_control == DIV_CODE);
  assign in_ready = !flush && !((r_state == WR1) && r_pend_dual);
  assign w_accept = in_valid && in_ready;
  // The last write of an instruction is already on the outputs, so it retires even under flush.
  assign w_last_write = ((r_state == WR1) && !r_pend_dual) || (r_state == WR2);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_pend_dual <= 1'b0;
      r_r15       <= '0;
      r_rf_we     <= 1'b0;
      r_rf_waddr  <= '0;
      r_rf_wdata  <= '0;
      r_retired   <= '0;
    end else begin
      if (w_last_write)
        r_retired <= r_retired + 16'd1;

      if (flush) begin
        r_state <= IDLE;
        r_rf_we <= 1'b0;
      end else if (w_accept) begin
        r_state     <= WR1;
        r_rf_we     <= w_dual || in_wr_en;
        r_rf_waddr  <= in_rd;
        r_rf_wdata  <= in_op1;
        r_pend_dual <= w_dual;
        r_r15       <= in_r15;
      end else if ((r_state == WR1) && r_pend_dual) begin
        r_state    <= WR2;
        r_rf_we    <= 1'b1;
        r_rf_waddr <= HI_REG;
        r_rf_wdata <= r_r15;
      end else begin
        r_state <= IDLE;
        r_rf_we <= 1'b0;
      end
    end
  end

  assign rf_we    = r_rf_we;
  assign rf_waddr = r_rf_waddr;
  assign rf_wdata = r_rf_wdata;
  assign retired  = r_retired;

endmodule
